prime_stream: RTL and testbench

- Downstream consumer of primogen. Drives primogen's `go`, captures each new prime when `ready` returns, and buffers it in a small FIFO.
- Presents the primes as a valid/ready stream, so later stages can take primes at their own rate without handling primogen's request protocol.
- Sits directly after primogen in the prime pipeline. The top level instantiates both and inverts `rst_n` to drive primogen's active-high `rst`.

---
 rtl/prime_stream_pkg.sv | 21 ++
 rtl/prime_stream_sync_fifo.sv | 80 ++++++++
 rtl/prime_stream.sv | 126 ++++++++++++
 tb/tb_prime_stream.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/prime_stream_pkg.sv
`default_nettype none
// ============================================================================
// Module      : prime_stream_pkg
// Description : Shared types for the prime_stream request/capture FSM.
// Revision    : 1.0 - initial release
// ============================================================================
package prime_stream_pkg;

  localparam int unsigned STATE_W = 3;

  // Request/capture sequencer states. Encodings 5..7 are unused.
  typedef enum logic [STATE_W-1:0] {
    ST_IDLE      = 3'd0,
    ST_ISSUE     = 3'd1,
    ST_WAIT_BUSY = 3'd2,
    ST_WAIT_DONE = 3'd3,
    ST_ERR       = 3'd4
  } state_t;

endpackage : prime_stream_pkg
`default_nettype wire

// File: rtl/prime_stream_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo
// Description : Synchronous first-word-fall-through FIFO. Head entry is
//               visible on dout whenever the FIFO is not empty.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo #(
  parameter int WIDTH     = 16,
  parameter int DEPTH_LOG = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 push,
  input  logic [WIDTH-1:0]     din,
  input  logic                 pop,
  output logic [WIDTH-1:0]     dout,
  output logic                 empty,
  output logic                 full,
  output logic [DEPTH_LOG:0]   occupancy
);

  localparam int                 DEPTH    = 1 << DEPTH_LOG;
  localparam logic [DEPTH_LOG:0] FULL_OCC = (DEPTH_LOG + 1)'(DEPTH);

  logic [WIDTH-1:0]     mem_q [DEPTH];
  logic [DEPTH_LOG-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG:0]   occ_q, occ_d;
  logic                 do_push;
  logic                 do_pop;

  // Qualify push/pop and advance pointers/occupancy; a push into a full
  // FIFO is accepted only when a pop frees the slot in the same cycle.
  always_comb begin
    do_pop   = pop && (occ_q != '0);
    do_push  = push && ((occ_q != FULL_OCC) || do_pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    if (do_push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({do_push, do_pop})
      2'b10:   occ_d = occ_q + 1'b1;
      2'b01:   occ_d = occ_q - 1'b1;
      default: occ_d = occ_q;
    endcase
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
    end
  end

  // Storage array; contents need no reset since occupancy gates visibility.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

  assign dout      = mem_q[rd_ptr_q];
  assign empty     = (occ_q == '0);
  assign full      = (occ_q == FULL_OCC);
  assign occupancy = occ_q;

endmodule : sync_fifo
`default_nettype wire

// File: rtl/prime_stream.sv
`default_nettype none
// ============================================================================
// Module      : prime_stream
// Description : Drives primogen's go/ready handshake, captures each result
//               and presents the primes as a valid/ready stream via a FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
module prime_stream
  import prime_stream_pkg::*;
#(
  parameter int WIDTH_LOG = 4,
  parameter int DEPTH_LOG = 3,
  parameter int CNT_W     = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          en,
  output logic                          gen_go,
  input  logic                          gen_ready,
  input  logic                          gen_error,
  input  logic [(1 << WIDTH_LOG)-1:0]   gen_res,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic [(1 << WIDTH_LOG)-1:0]   m_data,
  output logic                          full,
  output logic                          err,
  output logic [CNT_W-1:0]              count
);

  localparam int                 WIDTH = 1 << WIDTH_LOG;
  localparam int                 DEPTH = 1 << DEPTH_LOG;
  localparam logic [DEPTH_LOG:0] DEPTH_OCC = (DEPTH_LOG + 1)'(DEPTH);

  state_t             state_q, state_d;
  logic               gen_go_q, gen_go_d;
  logic               err_q, err_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               fifo_push;
  logic               fifo_pop;
  logic               fifo_empty;
  logic               fifo_full;
  logic [DEPTH_LOG:0] fifo_occ;

  // Sequencer: issue one request at a time, only when a FIFO slot is free,
  // so every captured result is guaranteed somewhere to land.
  always_comb begin
    state_d   = state_q;
    err_d     = err_q;
    count_d   = count_q;
    fifo_push = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (en && !err_q && (fifo_occ < DEPTH_OCC) && gen_ready) begin
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        state_d = ST_WAIT_BUSY;
      end
      ST_WAIT_BUSY: begin
        if (!gen_ready) begin
          state_d = ST_WAIT_DONE;
        end
      end
      ST_WAIT_DONE: begin
        if (gen_ready) begin
          if (gen_error) begin
            err_d   = 1'b1;
            state_d = ST_ERR;
          end else begin
            fifo_push = 1'b1;
            count_d   = count_q + 1'b1;
            state_d   = ST_IDLE;
          end
        end
      end
      ST_ERR: begin
        state_d = ST_ERR;
      end
      default: begin
        state_d = state_t'('x);
      end
    endcase
    gen_go_d = (state_d == ST_ISSUE);
  end

  // State, registered go, sticky error flag and emitted-prime counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      gen_go_q <= 1'b0;
      err_q    <= 1'b0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      gen_go_q <= gen_go_d;
      err_q    <= err_d;
      count_q  <= count_d;
    end
  end

  assign fifo_pop = !fifo_empty && m_ready;

  sync_fifo #(
    .WIDTH     (WIDTH),
    .DEPTH_LOG (DEPTH_LOG)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (fifo_push),
    .din       (gen_res),
    .pop       (fifo_pop),
    .dout      (m_data),
    .empty     (fifo_empty),
    .full      (fifo_full),
    .occupancy (fifo_occ)
  );

  assign gen_go  = gen_go_q;
  assign m_valid = !fifo_empty;
  assign full    = fifo_full;
  assign err     = err_q;
  assign count   = count_q;

endmodule : prime_stream
`default_nettype wire

// File: tb/tb_prime_stream.sv
`default_nettype none
// ============================================================================
// Module      : tb_prime_stream
// Description : Directed self-checking bench for prime_stream with a
//               behavioural primogen stand-in (fixed 3-cycle busy period,
//               error after the 54th prime, i.e. past 251).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_prime_stream;

  localparam int WIDTH     = 16;
  localparam int CNT_W     = 16;
  localparam int MODEL_LAT = 3;
  localparam int N_PRIMES  = 54;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             en = 1'b0;
  logic             gen_go;
  logic             gen_ready;
  logic             gen_error;
  logic [WIDTH-1:0] gen_res;
  logic             m_valid;
  logic             m_ready = 1'b0;
  logic [WIDTH-1:0] m_data;
  logic             full;
  logic             err;
  logic [CNT_W-1:0] count;

  int primes [N_PRIMES] = '{
      2,   3,   5,   7,  11,  13,  17,  19,  23,  29,
     31,  37,  41,  43,  47,  53,  59,  61,  67,  71,
     73,  79,  83,  89,  97, 101, 103, 107, 109, 113,
    127, 131, 137, 139, 149, 151, 157, 163, 167, 173,
    179, 181, 191, 193, 197, 199, 211, 223, 227, 229,
    233, 239, 241, 251};

  int               vectors = 0;
  int               miscompares = 0;
  int               go_pulses = 0;
  logic [WIDTH-1:0] popped [$];
  int               model_cnt;
  int               model_idx;

  always #5 clk = ~clk;

  prime_stream #(
    .WIDTH_LOG (4),
    .DEPTH_LOG (3),
    .CNT_W     (CNT_W)
  ) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .gen_go    (gen_go),
    .gen_ready (gen_ready),
    .gen_error (gen_error),
    .gen_res   (gen_res),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .full      (full),
    .err       (err),
    .count     (count)
  );

  // primogen stand-in: reset to ready=1/res=1, drop ready the cycle after
  // go, return the next prime after MODEL_LAT cycles.
  always @(posedge clk) begin
    if (!rst_n) begin
      gen_ready <= 1'b1;
      gen_res   <= 16'd1;
      gen_error <= 1'b0;
      model_cnt <= 0;
      model_idx <= 0;
    end else if (model_cnt != 0) begin
      if (model_cnt == 1) begin
        gen_ready <= 1'b1;
        if (model_idx >= N_PRIMES) begin
          gen_error <= 1'b1;
        end else begin
          gen_res   <= 16'(primes[model_idx]);
          model_idx <= model_idx + 1;
        end
      end
      model_cnt <= model_cnt - 1;
    end else if (gen_go && gen_ready) begin
      gen_ready <= 1'b0;
      model_cnt <= MODEL_LAT;
    end
  end

  // Record every accepted beat and every go pulse, away from the active edge.
  always @(negedge clk) begin
    if (rst_n && m_valid && m_ready) begin
      popped.push_back(m_data);
    end
    if (gen_go === 1'b1) begin
      go_pulses <= go_pulses + 1;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached (actual running, required finished)");
    $fatal(1);
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n   = 1'b0;
    en      = 1'b0;
    m_ready = 1'b0;
    step(2);
    rst_n = 1'b1;
    popped.delete();
  endtask

  // sel: 0 count==target, 1 gen_ready==0, 2 full==1, 3 err==1
  task automatic wait_cond(input int sel, input int target, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if ((sel == 0 && count == CNT_W'(target)) || (sel == 1 && gen_ready == 1'b0) ||
          (sel == 2 && full == 1'b1) || (sel == 3 && err == 1'b1)) begin
        ok = 1'b1;
        break;
      end
      step(1);
    end
  endtask

  task automatic test_reset();
    do_reset();
    vectors++; if (gen_go !== 1'b0) begin miscompares++; $display("FAIL reset_gen_go: got %0b, expected 0", gen_go); end
    vectors++; if (m_valid !== 1'b0) begin miscompares++; $display("FAIL reset_m_valid: got %0b, expected 0", m_valid); end
    vectors++; if (full !== 1'b0) begin miscompares++; $display("FAIL reset_full: got %0b, expected 0", full); end
    vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL reset_err: got %0b, expected 0", err); end
    vectors++; if (count !== 16'd0) begin miscompares++; $display("FAIL reset_count: got %0d, expected 0", count); end
  endtask

  task automatic test_en_low();
    int g0, valid_cycles;
    do_reset();
    m_ready = 1'b1;
    g0 = go_pulses;
    valid_cycles = 0;
    for (int i = 0; i < 50; i++) begin
      step(1);
      if (m_valid !== 1'b0) valid_cycles++;
    end
    vectors++; if (go_pulses - g0 !== 0) begin miscompares++; $display("FAIL en_low_go: got %0d pulses, expected 0", go_pulses - g0); end
    vectors++; if (valid_cycles !== 0) begin miscompares++; $display("FAIL en_low_valid: got %0d valid cycles, expected 0", valid_cycles); end
  endtask

  task automatic test_stream();
    bit ok;
    do_reset();
    en = 1'b1;
    m_ready = 1'b1;
    wait_cond(0, 6, 200, ok);
    en = 1'b0;
    vectors++; if (!ok) begin miscompares++; $display("FAIL stream_timeout: got count %0d, expected 6", count); end
    step(20);
    vectors++; if (count !== 16'd6) begin miscompares++; $display("FAIL stream_count: got %0d, expected 6", count); end
    vectors++; if (popped.size() !== 6) begin miscompares++; $display("FAIL stream_len: got %0d, expected 6", popped.size()); end
    for (int i = 0; i < 6; i++) begin
      vectors++;
      if (i >= popped.size() || popped[i] !== 16'(primes[i])) begin
        miscompares++;
        $display("FAIL stream_data[%0d]: got %0d, expected %0d", i, (i < popped.size()) ? popped[i] : 16'hffff, primes[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    int g0;
    do_reset();
    en = 1'b1;
    m_ready = 1'b0;
    wait_cond(2, 0, 400, ok);
    vectors++; if (!ok) begin miscompares++; $display("FAIL bp_fill_timeout: got full %0b, expected 1", full); end
    g0 = go_pulses;
    step(200);
    vectors++; if (count !== 16'd8) begin miscompares++; $display("FAIL bp_count: got %0d, expected 8", count); end
    vectors++; if (full !== 1'b1) begin miscompares++; $display("FAIL bp_full: got %0b, expected 1", full); end
    vectors++; if (go_pulses - g0 !== 0) begin miscompares++; $display("FAIL bp_go_idle: got %0d pulses, expected 0", go_pulses - g0); end
    vectors++; if (m_data !== 16'd2) begin miscompares++; $display("FAIL bp_head: got %0d, expected 2", m_data); end
    m_ready = 1'b1;
    wait_cond(0, 10, 300, ok);
    en = 1'b0;
    vectors++; if (!ok) begin miscompares++; $display("FAIL bp_drain_timeout: got count %0d, expected 10", count); end
    step(30);
    vectors++; if (popped.size() !== 10) begin miscompares++; $display("FAIL bp_len: got %0d, expected 10", popped.size()); end
    for (int i = 0; i < 10; i++) begin
      vectors++;
      if (i >= popped.size() || popped[i] !== 16'(primes[i])) begin
        miscompares++;
        $display("FAIL bp_data[%0d]: got %0d, expected %0d", i, (i < popped.size()) ? popped[i] : 16'hffff, primes[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    do_reset();
    en = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      if (count == 16'd20) begin ok = 1'b1; break; end
      m_ready = ~m_ready;
      step(1);
    end
    en = 1'b0;
    m_ready = 1'b1;
    vectors++; if (!ok) begin miscompares++; $display("FAIL b2b_timeout: got count %0d, expected 20", count); end
    step(30);
    vectors++; if (popped.size() !== 20) begin miscompares++; $display("FAIL b2b_len: got %0d, expected 20", popped.size()); end
    for (int i = 0; i < 20; i++) begin
      vectors++;
      if (i >= popped.size() || popped[i] !== 16'(primes[i])) begin
        miscompares++;
        $display("FAIL b2b_data[%0d]: got %0d, expected %0d", i, (i < popped.size()) ? popped[i] : 16'hffff, primes[i]);
      end
    end
  endtask

  task automatic test_overflow();
    bit ok;
    int g0;
    do_reset();
    en = 1'b1;
    m_ready = 1'b1;
    wait_cond(3, 0, 2000, ok);
    vectors++; if (!ok) begin miscompares++; $display("FAIL ovf_timeout: got err %0b, expected 1", err); end
    step(10);
    vectors++; if (count !== 16'd54) begin miscompares++; $display("FAIL ovf_count: got %0d, expected 54", count); end
    vectors++; if (popped.size() !== 54) begin miscompares++; $display("FAIL ovf_len: got %0d, expected 54", popped.size()); end
    vectors++;
    if (popped.size() == 0 || popped[popped.size()-1] !== 16'd251) begin
      miscompares++;
      $display("FAIL ovf_last: got %0d, expected 251", (popped.size() != 0) ? popped[popped.size()-1] : 16'hffff);
    end
    vectors++; if (m_valid !== 1'b0) begin miscompares++; $display("FAIL ovf_empty: got m_valid %0b, expected 0", m_valid); end
    g0 = go_pulses;
    step(100);
    vectors++; if (go_pulses - g0 !== 0) begin miscompares++; $display("FAIL ovf_go_dead: got %0d pulses, expected 0", go_pulses - g0); end
    vectors++; if (err !== 1'b1) begin miscompares++; $display("FAIL ovf_sticky: got err %0b, expected 1", err); end
    en = 1'b0;
  endtask

  task automatic test_en_drop();
    bit ok;
    int g0;
    do_reset();
    g0 = go_pulses;
    en = 1'b1;
    m_ready = 1'b1;
    wait_cond(1, 0, 20, ok);
    vectors++; if (!ok) begin miscompares++; $display("FAIL drop_timeout: got gen_ready %0b, expected 0", gen_ready); end
    step(1);
    en = 1'b0;
    step(50);
    vectors++; if (count !== 16'd1) begin miscompares++; $display("FAIL drop_count: got %0d, expected 1", count); end
    vectors++; if (popped.size() !== 1) begin miscompares++; $display("FAIL drop_len: got %0d, expected 1", popped.size()); end
    vectors++; if (popped.size() == 0 || popped[0] !== 16'd2) begin miscompares++; $display("FAIL drop_data: got %0d, expected 2", (popped.size() != 0) ? popped[0] : 16'hffff); end
    vectors++; if (go_pulses - g0 !== 1) begin miscompares++; $display("FAIL drop_go: got %0d pulses, expected 1", go_pulses - g0); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    do_reset();
    en = 1'b1;
    m_ready = 1'b0;
    wait_cond(0, 3, 200, ok);
    vectors++; if (!ok) begin miscompares++; $display("FAIL rmid_fill_timeout: got count %0d, expected 3", count); end
    wait_cond(1, 0, 20, ok);
    vectors++; if (!ok) begin miscompares++; $display("FAIL rmid_busy_timeout: got gen_ready %0b, expected 0", gen_ready); end
    step(1);
    rst_n = 1'b0;
    step(1);
    vectors++; if (m_valid !== 1'b0) begin miscompares++; $display("FAIL rmid_valid: got %0b, expected 0", m_valid); end
    vectors++; if (count !== 16'd0) begin miscompares++; $display("FAIL rmid_count: got %0d, expected 0", count); end
    vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL rmid_err: got %0b, expected 0", err); end
    vectors++; if (gen_go !== 1'b0) begin miscompares++; $display("FAIL rmid_go: got %0b, expected 0", gen_go); end
    rst_n = 1'b1;
    popped.delete();
    m_ready = 1'b1;
    wait_cond(0, 1, 100, ok);
    en = 1'b0;
    vectors++; if (!ok) begin miscompares++; $display("FAIL rmid_restart_timeout: got count %0d, expected 1", count); end
    step(10);
    vectors++; if (popped.size() == 0 || popped[0] !== 16'd2) begin miscompares++; $display("FAIL rmid_first: got %0d, expected 2", (popped.size() != 0) ? popped[0] : 16'hffff); end
  endtask

  initial begin
    test_reset();
    test_en_low();
    test_stream();
    test_backpressure();
    test_back_to_back();
    test_overflow();
    test_en_drop();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_prime_stream
`default_nettype wire
